init_reset_sequencer: RTL
=========================

INIT_RESET_SEQUENCER -- requirements
Module: init_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for every asynchronous input (legal range 2..4).
REQ-002 Parameter HOLD_CYCLES, default 16, sets the number of cycles FABRIC_RESET_N stays low after all init conditions are met (legal range 1..65535).
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, sets the WAIT_INIT watchdog limit (legal range 1..65535).
REQ-004 CLK  in  1  single clock for all sequential logic.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 FABRIC_POR_N  in  1  asynchronous power-on-reset status from the init monitor (low = POR active).
REQ-007 DEVICE_INIT_DONE  in  1  asynchronous device-init-complete status from the init monitor.
REQ-008 PLL_LOCK  in  1  asynchronous fabric PLL lock.
REQ-009 EXT_RST_N  in  1  asynchronous external/user reset request, active low.
REQ-010 FABRIC_RESET_N  out  1  registered fabric reset, active low.
REQ-011 READY  out  1  registered; high only in RUN.
REQ-012 STATE  out  3  registered state encoding, for debug.
REQ-013 TIMEOUT  out  1  sticky watchdog flag.

Function
REQ-014 Every asynchronous input shall pass through a SYNC_STAGES flop chain, giving por_s, init_s, lock_s and ext_s.
REQ-015 The states shall be IDLE=0, WAIT_INIT=1, HOLD=2, RUN=3 and FAULT=4.
REQ-016 IDLE -> WAIT_INIT when por_s=1 and ext_s=1.
REQ-017 WAIT_INIT -> HOLD when init_s=1 and lock_s=1; the hold counter is cleared on entry.
REQ-018 HOLD shall last exactly HOLD_CYCLES cycles, then go to RUN.
REQ-019 HOLD shall restart from count 0 if lock_s drops during HOLD, with the state going back to WAIT_INIT.
REQ-020 In any state, por_s=0 or ext_s=0 forces IDLE on the next edge, with all counters cleared; this has priority over every other transition.
REQ-021 In RUN, lock_s=0 or init_s=0 -> WAIT_INIT.
REQ-022 FABRIC_RESET_N and READY shall be registered, equal 1 exactly during the cycles STATE=RUN, and take no combinational path from the inputs.
REQ-023 Counters shall be 16-bit, saturate rather than wrap, and compare with ==.
REQ-024 If a collapse condition and an advance condition occur in the same cycle, the collapse wins.

Reset
REQ-025 While RESET=1, the block shall hold STATE=IDLE, FABRIC_RESET_N=0, READY=0, TIMEOUT=0, counters 0 and all synchronizer flops 0.
REQ-026 Assertion of RESET mid-operation shall act immediately and asynchronously.
REQ-027 Deassertion of RESET shall take effect at the next CLK edge.

Configuration
REQ-028 Macro INIT_RESET_SEQUENCER_TIMEOUT_EN, when defined, adds a WAIT_INIT watchdog counter.
REQ-029 With the macro defined, reaching TIMEOUT_CYCLES consecutive WAIT_INIT cycles shall go to FAULT and set TIMEOUT=1.
REQ-030 FAULT shall exit only via RESET or ext_s=0 (to IDLE); TIMEOUT clears only on RESET.
REQ-031 With the macro undefined, there is no watchdog and no FAULT state, and TIMEOUT shall be tied to 0; the port list is unchanged.

Structure
REQ-032 Package init_reset_sequencer_pkg shall hold the state enum (3-bit) and the counter width constant (16).
REQ-033 Sub-module init_reset_sync shall implement one parameterised N-stage synchronizer with asynchronous active-high clear, instantiated four times.

Verification (SYNC_STAGES=2, HOLD_CYCLES=4, TIMEOUT_CYCLES=32)
REQ-034 Power-up: release RESET, raise FABRIC_POR_N, EXT_RST_N, PLL_LOCK and DEVICE_INIT_DONE together -> FABRIC_RESET_N and READY rise exactly 2+1+1+4 edges later (sync, IDLE->WAIT_INIT, WAIT_INIT->HOLD, 4 HOLD cycles); STATE sequence 0,1,2,3.
REQ-035 PLL glitch in HOLD: drop PLL_LOCK for 1 cycle during HOLD count 2 -> STATE returns to 1, and HOLD restarts with a full 4 cycles after relock.
REQ-036 EXT_RST_N low while in RUN -> FABRIC_RESET_N=0 and STATE=0 exactly 3 edges after the fall; the full sequence replays on release.
REQ-037 Watchdog (macro defined): hold DEVICE_INIT_DONE low -> TIMEOUT=1 and STATE=4 after 32 WAIT_INIT cycles; raising DEVICE_INIT_DONE later does not leave FAULT; pulsing EXT_RST_N low does; TIMEOUT stays 1.
REQ-038 Macro undefined: the same stimulus leaves STATE=1 indefinitely (run 1000 cycles) with TIMEOUT=0.
REQ-039 Asynchronous RESET asserted mid-HOLD, between clock edges -> FABRIC_RESET_N=0, STATE=0 and READY=0 before the next CLK edge.

Source files
------------

// File: rtl/init_reset_sequencer_pkg.sv
// Shared types for the fabric reset sequencer: state encoding, counter width
// and the saturating increment used by every counter in the block.
package init_reset_sequencer_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/init_reset_sync.sv
// N-stage flop synchronizer with asynchronous active-high clear.
// Latency STAGES clock edges; no flow control.
module init_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/init_reset_sequencer.sv
// Fabric reset sequencer: gates FABRIC_RESET_N/READY on POR, init, PLL lock and external reset.
// Outputs registered, no flow control; INIT_RESET_SEQUENCER_TIMEOUT_EN adds a WAIT_INIT watchdog.
module init_reset_sequencer
    import init_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FABRIC_POR_N,
    input  logic       DEVICE_INIT_DONE,
    input  logic       PLL_LOCK,
    input  logic       EXT_RST_N,
    output logic       FABRIC_RESET_N,
    output logic       READY,
    output logic [2:0] STATE,
    output logic       TIMEOUT
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("init_reset_sequencer: parameter out of range");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic por_s, init_s, lock_s, ext_s;

    init_reset_sync #(.STAGES(SYNC_STAGES)) u_sync_por  (.clk_i(CLK), .rst_i(RESET), .d_i(FABRIC_POR_N),     .q_o(por_s));
    init_reset_sync #(.STAGES(SYNC_STAGES)) u_sync_init (.clk_i(CLK), .rst_i(RESET), .d_i(DEVICE_INIT_DONE), .q_o(init_s));
    init_reset_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (.clk_i(CLK), .rst_i(RESET), .d_i(PLL_LOCK),         .q_o(lock_s));
    init_reset_sync #(.STAGES(SYNC_STAGES)) u_sync_ext  (.clk_i(CLK), .rst_i(RESET), .d_i(EXT_RST_N),        .q_o(ext_s));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             ready_q, frn_q;
    logic             in_fault, collapse;

`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    assign in_fault = (state_q == ST_FAULT);
`else
    assign in_fault = 1'b0;
`endif

    assign collapse = !por_s || !ext_s;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (init_s && lock_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d   = ST_FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = sat_inc(wd_cnt_q);
                end
`endif
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d    = ST_WAIT_INIT;
                    hold_cnt_d = '0;
`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
                    wd_cnt_d   = '0;
`endif
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end
            ST_RUN: begin
                if (!lock_s || !init_s) begin
                    state_d = ST_WAIT_INIT;
`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end
`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_IDLE;
        endcase

        // FAULT is latched until the user pulls external reset; elsewhere any collapse wins.
        if (in_fault ? !ext_s : collapse) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
            wd_cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            ready_q    <= 1'b0;
            frn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ready_q    <= (state_d == ST_RUN);
            frn_q      <= (state_d == ST_RUN);
        end
    end

`ifdef INIT_RESET_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign FABRIC_RESET_N = frn_q;
    assign READY          = ready_q;
    assign STATE          = state_q;

endmodule
